// File: rtl/rx_block_lock.sv
// 64b/66b block-lock FSM: watches sync headers, requests gearbox slips until
// alignment is found, then monitors invalid-header rate per test window.
module rx_block_lock #(
   parameter int SH_CNT_MAX     = 64,
   parameter int SH_INVALID_MAX = 16,
   parameter int SLIP_WAIT      = 32
) (
   input  logic       i_rxc,
   input  logic       i_reset,
   input  logic       i_init_done,
   input  logic [1:0] i_rx_header,
   input  logic       i_rx_header_valid,
   output logic       o_slip,
   output logic       o_block_lock,
   output logic       o_rx_valid
);

   localparam int CW = $clog2(SH_CNT_MAX + 1);
   localparam int IW = $clog2(SH_INVALID_MAX + 1);
   localparam int WW = $clog2(SLIP_WAIT + 1);

   typedef enum logic [1:0] {ST_TEST, ST_SLIP, ST_WAIT} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   sh_cnt, sh_cnt_nx, cnt_inc;
   logic [IW-1:0]   inv_cnt, inv_cnt_nx, inv_inc;
   logic [WW-1:0]   wait_cnt, wait_cnt_nx;
   logic            clr, hdr_ok, eval, acq, drop;
   logic            slip_nx, lock_nx;

   // Transceiver not ready is treated exactly like reset
   assign clr     = i_reset || !i_init_done;
   assign hdr_ok  = i_rx_header[1] ^ i_rx_header[0];
   assign eval    = (state == ST_TEST) && i_rx_header_valid;
   assign cnt_inc = sh_cnt + 1'b1;
   assign inv_inc = inv_cnt + IW'(!hdr_ok);
   // Lock gained on the window-completing good header; lost on the header
   // that fills the invalid budget (wins over window completion)
   assign acq     = eval && !o_block_lock && hdr_ok && (cnt_inc == CW'(SH_CNT_MAX));
   assign drop    = eval && o_block_lock && (inv_inc == IW'(SH_INVALID_MAX));

   assign o_rx_valid = i_rx_header_valid && o_block_lock;

   // State and datapath registers
   always_ff @(posedge i_rxc) begin
      if (clr) begin
         state    <= ST_TEST;
         sh_cnt   <= '0;
         inv_cnt  <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         sh_cnt   <= sh_cnt_nx;
         inv_cnt  <= inv_cnt_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   // Next-state and counter update
   always_comb begin
      state_nx    = state;
      sh_cnt_nx   = sh_cnt;
      inv_cnt_nx  = inv_cnt;
      wait_cnt_nx = wait_cnt;
      case (state)
         ST_TEST: begin
            if (eval) begin
               if (!o_block_lock) begin
                  if (!hdr_ok) begin
                     state_nx   = ST_SLIP;
                     sh_cnt_nx  = '0;
                     inv_cnt_nx = '0;
                  end else if (acq) begin
                     sh_cnt_nx  = '0;
                     inv_cnt_nx = '0;
                  end else begin
                     sh_cnt_nx  = cnt_inc;
                  end
               end else begin
                  if (drop) begin
                     state_nx   = ST_SLIP;
                     sh_cnt_nx  = '0;
                     inv_cnt_nx = '0;
                  end else if (cnt_inc == CW'(SH_CNT_MAX)) begin
                     sh_cnt_nx  = '0;
                     inv_cnt_nx = '0;
                  end else begin
                     sh_cnt_nx  = cnt_inc;
                     inv_cnt_nx = inv_inc;
                  end
               end
            end
         end
         ST_SLIP: begin
            state_nx    = ST_WAIT;
            wait_cnt_nx = WW'(SLIP_WAIT - 1);
         end
         ST_WAIT: begin
            if (wait_cnt == '0) begin
               state_nx   = ST_TEST;
               sh_cnt_nx  = '0;
               inv_cnt_nx = '0;
            end else begin
               wait_cnt_nx = wait_cnt - 1'b1;
            end
         end
         default: state_nx = ST_TEST;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      slip_nx = (state_nx == ST_SLIP);
      lock_nx = o_block_lock ? !drop : acq;
   end

   // Output registers: slip is high exactly while the FSM sits in SLIP
   always_ff @(posedge i_rxc) begin
      if (clr) begin
         o_slip       <= 1'b0;
         o_block_lock <= 1'b0;
      end else begin
         o_slip       <= slip_nx;
         o_block_lock <= lock_nx;
      end
   end

endmodule

// File: tb/tb_rx_block_lock.sv
// Directed scoreboard bench for rx_block_lock.
module tb_rx_block_lock;

   logic       i_rxc = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_init_done = 1'b1;
   logic [1:0] i_rx_header = 2'b01;
   logic       i_rx_header_valid = 1'b0;
   logic       o_slip, o_block_lock, o_rx_valid;

   typedef struct packed {
      logic slip;
      logic lock;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   bit   alt   = 1'b0;

   rx_block_lock dut (
      .i_rxc             (i_rxc),
      .i_reset           (i_reset),
      .i_init_done       (i_init_done),
      .i_rx_header       (i_rx_header),
      .i_rx_header_valid (i_rx_header_valid),
      .o_slip            (o_slip),
      .o_block_lock      (o_block_lock),
      .o_rx_valid        (o_rx_valid)
   );

   always #5 i_rxc = ~i_rxc;

   task automatic chk(input string name, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
      end
   endtask

   // Monitor: registered outputs checked mid-cycle against queued expectations;
   // rx_valid must follow the currently driven valid gated by expected lock
   always @(negedge i_rxc) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("slip", o_slip, e.slip);
         chk("lock", o_block_lock, e.lock);
         chk("rx_valid", o_rx_valid, i_rx_header_valid && e.lock);
      end
   end

   // One block: drive inputs, let the edge sample them, queue post-edge outputs
   task automatic step(input logic [1:0] h, input logic v, input logic es, input logic el);
      i_rx_header       = h;
      i_rx_header_valid = v;
      @(posedge i_rxc);
      exp_q.push_back('{slip: es, lock: el});
      #1;
   endtask

   function automatic logic [1:0] good_hdr();
      alt = ~alt;
      return alt ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] bad_hdr();
      alt = ~alt;
      return alt ? 2'b00 : 2'b11;
   endfunction

   // n good headers; lock expected lk throughout except lk_end after the last
   task automatic run_good(input int n, input logic lk, input logic lk_end);
      for (int i = 1; i <= n; i++) step(good_hdr(), 1'b1, 1'b0, (i == n) ? lk_end : lk);
   endtask

   // n invalid headers presented while they must be ignored (SLIP/WAIT)
   task automatic run_ignored(input int n);
      for (int i = 0; i < n; i++) step(bad_hdr(), 1'b1, 1'b0, 1'b0);
   endtask

   // One locked window of 64 headers, 15 invalid at positions 4,8,..,60
   task automatic tolerated_window();
      for (int i = 1; i <= 64; i++)
         step((i % 4 == 0 && i <= 60) ? 2'b11 : good_hdr(), 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      i_reset = 1'b1;
      for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 1'b0, 1'b0);
      i_reset = 1'b0;

      // Lock acquisition: 0 after 63rd, 1 after 64th
      run_good(64, 1'b0, 1'b1);

      // Tolerated errors in two consecutive windows
      tolerated_window();
      tolerated_window();

      // Valid gating: 00 on every non-valid cycle must not count (20 of them)
      for (int i = 0; i < 40; i++) begin
         if (i % 2 == 0) step(good_hdr(), 1'b1, 1'b0, 1'b1);
         else            step(2'b00, 1'b0, 1'b0, 1'b1);
      end
      // 20 counted so far; 44 more complete the window
      run_good(44, 1'b1, 1'b1);

      // Loss of lock: 16th invalid lands on window position 64
      run_good(48, 1'b1, 1'b1);
      for (int i = 49; i <= 63; i++) step(bad_hdr(), 1'b1, 1'b0, 1'b1);
      step(2'b11, 1'b1, 1'b1, 1'b0);
      // SLIP cycle plus 32 WAIT cycles ignore invalid headers
      run_ignored(33);
      // First evaluated header after the wait: invalid -> immediate slip
      step(2'b00, 1'b1, 1'b1, 1'b0);

      // Reset in the middle of WAIT, then re-acquire from scratch
      run_ignored(5);
      i_reset = 1'b1;
      step(2'b00, 1'b1, 1'b0, 1'b0);
      i_reset = 1'b0;
      run_good(64, 1'b0, 1'b1);

      // Drop init_done while locked
      i_init_done = 1'b0;
      step(good_hdr(), 1'b1, 1'b0, 1'b0);
      step(good_hdr(), 1'b1, 1'b0, 1'b0);
      i_init_done = 1'b1;

      // Slip when unlocked: 9 good, 10th = 00
      run_good(9, 1'b0, 1'b0);
      step(2'b00, 1'b1, 1'b1, 1'b0);
      run_ignored(33);
      run_good(64, 1'b0, 1'b1);

      @(negedge i_rxc);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
